rv32_inst_encoder: RTL
======================

// Module: rv32_inst_encoder
// PURPOSE
//  Assembles RV32I instruction words from field-level descriptions (format, opcode, regs,
//  funct, immediate) and writes them sequentially into instruction memory. It is the
//  encode/write end of the opcode/field contract that the control unit decodes; the
//  bench and boot loader use it to build programs in place.
// PARAMETERS
//  ADDR_W     6   word-address width of target instruction memory (depth 2**ADDR_W)
//  BASE_ADDR  0   first word address written after reset/start
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       synchronous reset, active-low
//  start      in   1       restart program: clear addr counter, full, err state
//  in_valid   in   1       field beat valid
//  in_ready   out  1       beat accepted on clk edge when in_valid & in_ready
//  in_fmt     in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal (shared package)
//  in_opcode  in   7       opcode, passed through to bits [6:0] unchecked
//  in_rd      in   5       rd field (R/I/U/J)
//  in_rs1     in   5       rs1 field (R/I/S/B)
//  in_rs2     in   5       rs2 field (R/S/B)
//  in_funct3  in   3       funct3 (R/I/S/B)
//  in_funct7  in   7       funct7 (R only)
//  in_imm     in   32      full signed immediate value (byte offset for B/J)
//  mem_we     out  1       instruction-memory write strobe, one cycle per word
//  mem_addr   out  ADDR_W  word address of the write
//  mem_wdata  out  32      encoded instruction word
//  full       out  1       last location written; no further beats accepted
//  err        out  1       sticky: at least one beat rejected since reset/start
//  err_cnt    out  8       rejected-beat count, saturates at 255
//  wr_cnt     out  ADDR_W+1 words written since reset/start
// BEHAVIOUR
//  Reset (rst_n=0 at edge): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, full=0, err=0,
//   err_cnt=0, wr_cnt=0, FSM=IDLE; in_ready=0 during reset cycle. Reset mid-write drops
//   the pending word (mem_we=0 next cycle).
//  FSM: IDLE -> RUN on first accepted beat or start; RUN -> FULL when word at address
//   2**ADDR_W-1 is written; FULL -> RUN only via start. in_ready = rst_n & ~start & ~full.
//  Pipeline: beat accepted at edge N is encoded and checked into a 1-entry stage reg;
//   mem_we=1 with mem_addr/mem_wdata during cycle N+1 (latency 1). Back-to-back beats
//   yield back-to-back writes, throughput 1 word/clk. Memory write assumed single-cycle.
//  Address counter increments after every write; no wrap: writing top address sets full
//   the same edge, in_ready falls the next cycle (beat in same edge as last write is not
//   accepted because full is registered from the prior-accept count, i.e. accept is
//   blocked when wr_cnt + pending == 2**ADDR_W).
//  Encoding (standard RV32I bit placement):
//   R: f7|rs2|rs1|f3|rd|op   I: imm[11:0]|rs1|f3|rd|op   S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//   B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op   U: imm[31:12]|rd|op
//   J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
//  Range checks (reject -> no write, err=1, err_cnt+1, counters unchanged):
//   I/S: imm in [-2048,2047]; B: [-4096,4094] and imm[0]=0; J: [-2^20,2^20-2] and
//   imm[0]=0; U: imm[11:0]=0; fmt 6/7 always rejected. Rejected beats still handshake.
//  start: one-cycle clear of counters/full/err/err_cnt, addr=BASE_ADDR; beat presented
//   with start is not accepted; a pending write in the stage reg still completes at its
//   old address, and the counter clear takes precedence over that increment.
// STRUCTURE
//  Shared package (defines.v): FMT_R..FMT_J codes, OPCODE_* values, immediate range
//   limits. Sub-module inst_imm_packer: combinational fmt+imm -> placed immediate bits +
//   range_ok flag; top holds FSM, stage reg, counters.
// TESTING
//  R add x3,x1,x2 (op 0x33,f3 0,f7 0) -> mem_we next cycle, addr 0, wdata 0x002081B3
//  I addi x1,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00093; S sw x2,8(x1) -> 0x0020A423
//  B beq x1,x2,-4 -> 0xFE208EE3; U lui x5,0x12345000 -> 0x123452B7; back-to-back, addr 0..4
//  B imm=3, then I imm=4096 -> no mem_we, err=1, err_cnt=2, addr unchanged
//  ADDR_W=2: 4 beats -> full=1 after 4th write, in_ready=0; 5th beat held; start -> addr 0
//  rst_n low one cycle after accept -> no write issued, all outputs at reset values

Source files
------------

// File: rtl/rv32_inst_encoder_pkg.sv
// ============================================================================
// rv32_inst_encoder_pkg: format codes, opcodes, immediate limits, FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32_inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -(1 << 20);
  localparam int IMMJ_MAX  = (1 << 20) - 2;

endpackage

`default_nettype wire

// File: rtl/rv32_inst_encoder_if.sv
// ============================================================================
// rv32_inst_encoder_if: field-beat input and instruction-memory write bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface rv32_inst_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              full;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   wr_cnt;

  modport master (
    output start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, full, err, err_cnt, wr_cnt
  );

  modport slave (
    input  start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, full, err, err_cnt, wr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/rv32_inst_encoder_imm_packer.sv
// ============================================================================
// rv32_inst_encoder_imm_packer: places immediate bits per format, range check
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32_inst_encoder_imm_packer
  import rv32_inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_ok
);

  logic signed [31:0] simm;
  assign simm = imm;

  always_comb begin
    imm_bits = '0;
    range_ok = 1'b0;
    case (fmt)
      FMT_R: range_ok = 1'b1;
      FMT_I: begin
        imm_bits[31:20] = imm[11:0];
        range_ok        = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_ok        = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        range_ok        = (simm >= IMMB_MIN) && (simm <= IMMB_MAX) && !imm[0];
      end
      FMT_U: begin
        imm_bits[31:12] = imm[31:12];
        range_ok        = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        range_ok        = (simm >= IMMJ_MIN) && (simm <= IMMJ_MAX) && !imm[0];
      end
      default: range_ok = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32_inst_encoder.sv
// ============================================================================
// rv32_inst_encoder: encodes RV32I field beats and writes them to imem in order
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32_inst_encoder
  import rv32_inst_encoder_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rv32_inst_encoder_if.slave bus
);

  localparam logic [ADDR_W:0]   CAP      = (ADDR_W + 1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_e            state;
  logic              stage_v;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic              full_q;
  logic              err_q;
  logic [7:0]        ecnt;

  logic [31:0] fields;
  logic [31:0] imm_bits;
  logic        range_ok;
  logic        accept;
  logic        wrote_top;

  rv32_inst_encoder_imm_packer u_imm_packer (
    .fmt      (bus.in_fmt),
    .imm      (bus.in_imm),
    .imm_bits (imm_bits),
    .range_ok (range_ok)
  );

  always_comb begin
    fields      = '0;
    fields[6:0] = bus.in_opcode;
    case (bus.in_fmt)
      FMT_R: begin
        fields[31:25] = bus.in_funct7;
        fields[24:20] = bus.in_rs2;
        fields[19:15] = bus.in_rs1;
        fields[14:12] = bus.in_funct3;
        fields[11:7]  = bus.in_rd;
      end
      FMT_I: begin
        fields[19:15] = bus.in_rs1;
        fields[14:12] = bus.in_funct3;
        fields[11:7]  = bus.in_rd;
      end
      FMT_S, FMT_B: begin
        fields[24:20] = bus.in_rs2;
        fields[19:15] = bus.in_rs1;
        fields[14:12] = bus.in_funct3;
      end
      FMT_U, FMT_J: fields[11:7] = bus.in_rd;
      default: fields[6:0] = bus.in_opcode;
    endcase
  end

  // Words already accepted but not yet written still consume a slot, so the
  // last free location is never double-booked by a beat arriving with its write.
  assign bus.in_ready = rst_n & ~bus.start & ~full_q &
                        ((cnt + (ADDR_W + 1)'(stage_v)) < CAP);
  assign accept    = bus.in_valid & bus.in_ready;
  assign wrote_top = stage_v && (addr == TOP_ADDR);

  assign bus.mem_we    = stage_v & rst_n;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.full      = full_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = ecnt;
  assign bus.wr_cnt    = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stage_v <= 1'b0;
      wdata   <= '0;
      addr    <= BASE;
      cnt     <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt    <= '0;
    end else begin
      stage_v <= accept & range_ok;
      if (accept & range_ok) wdata <= fields | imm_bits;
      if (accept & ~range_ok) begin
        err_q <= 1'b1;
        if (ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
      end
      // A write completing during start lands at its old address; the clear wins.
      if (bus.start) begin
        state  <= S_RUN;
        addr   <= BASE;
        cnt    <= '0;
        full_q <= 1'b0;
        err_q  <= 1'b0;
        ecnt   <= '0;
      end else begin
        if (stage_v) begin
          cnt <= cnt + (ADDR_W + 1)'(1);
          if (addr != TOP_ADDR) addr <= addr + ADDR_W'(1);
        end
        case (state)
          S_IDLE:  if (accept) state <= S_RUN;
          S_RUN: begin
            if (wrote_top) begin
              state  <= S_FULL;
              full_q <= 1'b1;
            end
          end
          S_FULL:  state <= S_FULL;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
